bus_rr_matrix: RTL and testbench

- Parametrised successor to the single-master two-slave bus: NUM_M masters share one transfer path to NUM_S slaves (memories, compute cores).
- Masters are arbitrated round-robin, and an owner holds the grant while it keeps requesting.
- The slave is chosen by upper-address decode. One-cycle read data returns to the issuing master with a valid strobe.
- Unmapped accesses and bus hogging are flagged.

---
 rtl/bus_rr_matrix_pkg.sv | 11 +
 rtl/bus_rr_matrix_arbiter.sv | 48 ++++
 rtl/bus_rr_matrix.sv | 93 +++++++++
 tb/tb_bus_rr_matrix.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_matrix_pkg.sv
// bus_rr_matrix_pkg: shared defaults and slicing macros for the round-robin bus matrix
// Macros: BRM_IDX picks the slave index from the top address bits,
//         BRM_SLICE picks element i of width w from a packed port vector.
`define BRM_IDX(a, aw, iw) a[(aw)-1 -: (iw)]
`define BRM_SLICE(v, i, w) v[(i)*(w) +: (w)]
package bus_rr_matrix_pkg;
    localparam int DEF_AW    = 16;
    localparam int DEF_DW    = 64;
    localparam int DEF_IDX_W = 3;
    localparam int ERR_RDATA = 0;
endpackage

// File: rtl/bus_rr_matrix_arbiter.sv
// rr_arbiter: round-robin arbiter with grant hold, lockout mask and forced release
// Ports: clk, reset (sync, active-high); req, lockout per master; rel forces the
//        current owner off; grant is the registered one-hot grant, owner its index.
module rr_arbiter
    import bus_rr_matrix_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int OW    = NUM_M > 1 ? $clog2(NUM_M) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_M-1:0] req,
    input  logic [NUM_M-1:0] lockout,
    input  logic             rel,
    output logic [NUM_M-1:0] grant,
    output logic [OW-1:0]    owner
);
    logic [OW-1:0]    ptr;
    logic [OW-1:0]    win;
    logic [NUM_M-1:0] elig;
    logic             found;
    logic             hold;
    assign hold = (|grant) & req[owner] & ~rel;
    // a released owner may not win the edge that releases it
    assign elig = req & ~lockout & ~(rel ? grant : '0);
    // scan downwards so the candidate closest to ptr is the last to win
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int j = NUM_M - 1; j >= 0; j--) begin
            if (elig[(int'(ptr) + j) % NUM_M]) begin
                found = 1'b1;
                win   = OW'((int'(ptr) + j) % NUM_M);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
        end else if (!hold) begin
            grant <= found ? NUM_M'(1) << win : '0;
            owner <= win;
            if (found) ptr <= (int'(win) == NUM_M - 1) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: rtl/bus_rr_matrix.sv
// bus_rr_matrix: NUM_M masters share one round-robin path to NUM_S address-decoded slaves
// Ports: clk, reset (sync, active-high);
//        m_req/m_wr/m_addr/m_dout  packed master requests, master i at [i*W +: W];
//        m_grant one-hot registered grant; m_din shared read data; m_rvalid per master;
//        s_sel/s_wr/s_addr/s_din forwarded access; s_dout packed slave read data (1-cycle);
//        dec_err pulses on an unmapped access; timeout_err pulses on a watchdog release.
module bus_rr_matrix
    import bus_rr_matrix_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int NUM_S       = 4,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_M-1:0]    m_req,
    input  logic [NUM_M-1:0]    m_wr,
    input  logic [NUM_M*AW-1:0] m_addr,
    input  logic [NUM_M*DW-1:0] m_dout,
    output logic [NUM_M-1:0]    m_grant,
    output logic [DW-1:0]       m_din,
    output logic [NUM_M-1:0]    m_rvalid,
    output logic [NUM_S-1:0]    s_sel,
    output logic                s_wr,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_din,
    input  logic [NUM_S*DW-1:0] s_dout,
    output logic                dec_err,
    output logic                timeout_err
);
    localparam int OW = NUM_M > 1 ? $clog2(NUM_M) : 1;
    localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    logic [OW-1:0]    owner;
    logic [OW-1:0]    rd_m;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CW-1:0]    cnt;
    logic [NUM_M-1:0] lockout;
    logic [DW-1:0]    din_q;
    logic             granted;
    logic             xfer;
    logic             mapped;
    logic             rel;
    logic             rd_v;
    logic             rd_map;
    rr_arbiter #(.NUM_M(NUM_M), .OW(OW)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (m_req),
        .lockout (lockout),
        .rel     (rel),
        .grant   (m_grant),
        .owner   (owner)
    );
    assign granted = |m_grant;
    assign xfer    = granted & m_req[owner];
    assign s_wr    = granted & m_wr[owner];
    assign s_addr  = granted ? `BRM_SLICE(m_addr, owner, AW) : '0;
    assign s_din   = granted ? `BRM_SLICE(m_dout, owner, DW) : '0;
    assign idx     = `BRM_IDX(s_addr, AW, IDX_W);
    assign mapped  = int'(idx) < NUM_S;
    assign s_sel   = (xfer & mapped) ? NUM_S'(1) << idx : '0;
    assign rel     = (TIMEOUT_CYC != 0) && xfer && cnt == CW'(TIMEOUT_CYC - 1);
    // read data is steered by the registered issuer, so a grant move cannot misroute it
    assign m_rvalid = rd_v ? NUM_M'(1) << rd_m : '0;
    assign m_din    = rd_v ? (rd_map ? `BRM_SLICE(s_dout, rd_idx, DW) : DW'(ERR_RDATA)) : din_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_v        <= 1'b0;
            rd_m        <= '0;
            rd_idx      <= '0;
            rd_map      <= 1'b0;
            din_q       <= '0;
            dec_err     <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            lockout     <= '0;
        end else begin
            rd_v        <= xfer & ~s_wr;
            rd_m        <= owner;
            rd_idx      <= idx;
            rd_map      <= mapped;
            din_q       <= m_din;
            dec_err     <= xfer & ~mapped;
            timeout_err <= rel;
            cnt         <= (xfer & ~rel) ? cnt + 1'b1 : '0;
            lockout     <= (lockout & m_req) | (rel ? m_grant : '0);
        end
    end
endmodule

// File: tb/tb_bus_rr_matrix.sv
// tb_bus_rr_matrix: directed and random stimulus checked against a cycle-level bus model
module tb_bus_rr_matrix;
    localparam int NM = 3;
    localparam int NS = 4;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int IW = 3;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM-1:0]     m_req;
    logic [NM-1:0]     m_wr;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_dout;
    logic [NM-1:0]     m_grant;
    logic [DW-1:0]     m_din;
    logic [NM-1:0]     m_rvalid;
    logic [NS-1:0]     s_sel;
    logic              s_wr;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_din;
    logic [NS*DW-1:0]  s_dout = '0;
    logic              dec_err;
    logic              timeout_err;

    always #5 clk = ~clk;

    bus_rr_matrix #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .IDX_W(IW), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .m_req       (m_req),
        .m_wr        (m_wr),
        .m_addr      (m_addr),
        .m_dout      (m_dout),
        .m_grant     (m_grant),
        .m_din       (m_din),
        .m_rvalid    (m_rvalid),
        .s_sel       (s_sel),
        .s_wr        (s_wr),
        .s_addr      (s_addr),
        .s_din       (s_din),
        .s_dout      (s_dout),
        .dec_err     (dec_err),
        .timeout_err (timeout_err)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 64'hA5A5_0000_0000_0000 | 64'(a) | (64'(a) << 24);
    endfunction

    // slave stubs: synchronous memories that answer the cycle after select
    logic [DW-1:0] smem [int];
    always @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (s_sel[k]) begin
                if (s_wr) smem[int'(s_addr)] = s_din;
                else s_dout[k*DW +: DW] <= smem.exists(int'(s_addr)) ? smem[int'(s_addr)] : init_val(s_addr);
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // reference model state: who owns the bus, where the round-robin search starts,
    // who is locked out, how long the owner has held, and what is due next cycle
    logic [DW-1:0] mmem [int];
    int            own = -1;
    int            ptr = 0;
    int            cnt = 0;
    bit            lock [NM];
    bit            pend = 0;
    int            pend_m = 0;
    logic [DW-1:0] pend_d = '0;
    logic [DW-1:0] din_last = '0;
    bit            dec_p = 0;
    bit            to_p = 0;
    bit            chk_en = 0;
    bit            lastx = 0;

    task automatic cycle(input bit rst, input logic [NM-1:0] rq, input logic [NM-1:0] w,
                         input logic [NM*AW-1:0] a, input logic [NM*DW-1:0] d);
        logic [NM-1:0] e_grant;
        logic [NM-1:0] e_rv;
        logic [NS-1:0] e_sel;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic [DW-1:0] e_sdin;
        logic          e_wr;
        bit            xfer;
        bit            mapped;
        bit            tmo;
        bit            found;
        int            idx;
        int            win;
        int            start;
        int            old_own;
        reset  = rst;
        m_req  = rq;
        m_wr   = w;
        m_addr = a;
        m_dout = d;
        e_grant = '0;
        e_addr  = '0;
        e_sdin  = '0;
        e_wr    = 1'b0;
        xfer    = 0;
        if (own >= 0) begin
            e_grant[own] = 1'b1;
            e_addr = a[own*AW +: AW];
            e_sdin = d[own*DW +: DW];
            e_wr   = w[own];
            xfer   = rq[own];
        end
        idx    = int'(e_addr) >> (AW - IW);
        mapped = idx < NS;
        e_sel  = '0;
        if (xfer && mapped) e_sel[idx] = 1'b1;
        e_rv = '0;
        if (pend) e_rv[pend_m] = 1'b1;
        e_din = pend ? pend_d : din_last;
        @(negedge clk);
        if (chk_en) begin
            chk("grant", 64'(m_grant), 64'(e_grant));
            chk("rvalid", 64'(m_rvalid), 64'(e_rv));
            chk("m_din", m_din, e_din);
            chk("s_sel", 64'(s_sel), 64'(e_sel));
            chk("s_wr", 64'(s_wr), 64'(e_wr));
            chk("s_addr", 64'(s_addr), 64'(e_addr));
            chk("s_din", s_din, e_sdin);
            chk("dec_err", 64'(dec_err), 64'(dec_p));
            chk("timeout_err", 64'(timeout_err), 64'(to_p));
        end
        pend_d = mapped ? (mmem.exists(int'(e_addr)) ? mmem[int'(e_addr)] : init_val(e_addr)) : '0;
        // the slaves see a write even in a reset cycle, so memory follows it regardless
        if (xfer && e_wr && mapped) mmem[int'(e_addr)] = e_sdin;
        if (rst) begin
            own = -1; ptr = 0; cnt = 0; pend = 0; pend_m = 0;
            din_last = '0; dec_p = 0; to_p = 0; lastx = 0;
            for (int i = 0; i < NM; i++) lock[i] = 0;
            chk_en = 1;
        end else begin
            din_last = e_din;
            tmo      = xfer && TO != 0 && cnt == TO - 1;
            pend     = xfer && !e_wr;
            pend_m   = own;
            dec_p    = xfer && !mapped;
            to_p     = tmo;
            lastx    = xfer;
            old_own  = own;
            if (xfer && !tmo) cnt++;
            else begin
                start = tmo ? (own + 1) % NM : ptr;
                found = 0;
                win   = -1;
                for (int j = 0; j < NM; j++) begin
                    int c;
                    c = (start + j) % NM;
                    if (!found && rq[c] && !lock[c] && !(tmo && c == own)) begin
                        found = 1;
                        win   = c;
                    end
                end
                ptr = found ? (win + 1) % NM : start;
                own = win;
                cnt = 0;
            end
            for (int i = 0; i < NM; i++) lock[i] = lock[i] && rq[i];
            if (tmo) lock[old_own] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [NM-1:0]    rq;
    logic [NM-1:0]    wr;
    logic [NM*AW-1:0] ad;
    logic [NM*DW-1:0] dt;

    task automatic rand_addr_data();
        for (int i = 0; i < NM; i++) begin
            ad[i*AW +: AW] = {3'($urandom_range(0, 7)), 9'd0, 4'($urandom)};
            dt[i*DW +: DW] = {$urandom, $urandom};
        end
    endtask

    initial begin
        rq = '0; wr = '0; ad = '0; dt = '0;
        repeat (2) cycle(1, '0, '0, '0, '0);

        // single master write 0x1234 to 0x0008, then read it back
        ad = {16'h0, 16'h0, 16'h0008};
        dt = {64'h0, 64'h0, 64'h1234};
        cycle(0, 3'b001, 3'b001, ad, dt);
        cycle(0, 3'b001, 3'b001, ad, dt);
        cycle(0, 3'b001, 3'b000, ad, dt);
        cycle(0, 3'b000, 3'b000, ad, dt);
        cycle(0, 3'b000, 3'b000, ad, dt);
        chk("wr_rd_data_held", m_din, 64'h1234);

        // two masters, one transfer each per ownership
        cycle(1, '0, '0, '0, '0);
        for (int n = 0; n < 12; n++) begin
            rq = 3'b011;
            if (own >= 0 && lastx) rq[own] = 1'b0;
            rand_addr_data();
            cycle(0, rq, 3'($urandom), ad, dt);
        end

        // M0 holds for 5 transfers while M1 waits
        cycle(1, '0, '0, '0, '0);
        cycle(0, 3'b011, 3'b000, ad, dt);
        for (int n = 0; n < 5; n++) begin
            rand_addr_data();
            cycle(0, 3'b011, 3'b000, ad, dt);
        end
        for (int n = 0; n < 3; n++) cycle(0, 3'b010, 3'b000, ad, dt);

        // unmapped read and write at 0xA000
        cycle(1, '0, '0, '0, '0);
        ad = {16'h0, 16'h0, 16'hA000};
        cycle(0, 3'b001, 3'b000, ad, dt);
        cycle(0, 3'b001, 3'b000, ad, dt);
        cycle(0, 3'b001, 3'b001, ad, dt);
        cycle(0, 3'b000, 3'b000, ad, dt);
        cycle(0, 3'b000, 3'b000, ad, dt);

        // watchdog: both hold forever, then M0 releases and re-requests
        cycle(1, '0, '0, '0, '0);
        for (int n = 0; n < 22; n++) begin
            rand_addr_data();
            cycle(0, 3'b011, 3'($urandom), ad, dt);
        end
        cycle(0, 3'b010, 3'b000, ad, dt);
        for (int n = 0; n < 4; n++) cycle(0, 3'b011, 3'b000, ad, dt);

        // reset in the middle of a read burst, then both request
        cycle(1, '0, '0, '0, '0);
        for (int n = 0; n < 4; n++) begin
            rand_addr_data();
            cycle(0, 3'b001, 3'b000, ad, dt);
        end
        cycle(1, 3'b001, 3'b000, ad, dt);
        for (int n = 0; n < 4; n++) cycle(0, 3'b011, 3'b000, ad, dt);

        // random traffic with sticky requests and occasional resets
        rq = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NM; i++) if ($urandom_range(0, 3) == 0) rq[i] = ~rq[i];
            rand_addr_data();
            cycle($urandom_range(0, 199) == 0, rq, 3'($urandom), ad, dt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
